// File: rtl/layer_compositor.sv
// N-layer priority pixel compositor with a divisible once-per-frame tick generator.
// Optional blink gating of selected layers is compiled in with COMPOSITOR_BLINK_EN.
module layer_compositor #(
  parameter int N_LAYERS     = 4,
  parameter int TICK_X       = 0,
  parameter int TICK_Y       = 481,
  parameter int FRAME_DIV    = 1,
  parameter int HOLD_CYCLES  = 2,
  parameter int BLINK_PERIOD = 30
) (
  input  logic                     clk,
  input  logic                     reset_game,
  input  logic                     active,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  input  logic [N_LAYERS-1:0]      layer_on,
  input  logic [12*N_LAYERS-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]      layer_mask,
  input  logic [N_LAYERS-1:0]      blink_mask,
  input  logic [11:0]              bg_rgb,
  output logic [11:0]              RGB_Out,
  output logic                     layer_hit,
  output logic [3:0]               layer_sel,
  output logic                     frame_tick,
  output logic [15:0]              frame_count
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [7:0]        div_cnt, div_nxt;
  logic [3:0]        hold_cnt, hold_nxt;
  logic              trig;
  logic [N_LAYERS-1:0] vis;
  logic              win_hit;
  logic [3:0]        win_sel;
  logic [11:0]       win_rgb;

  assign trig = (pixel_x == 10'(TICK_X)) && (pixel_y == 10'(TICK_Y));

`ifdef COMPOSITOR_BLINK_EN
  logic       blink_phase;
  logic [7:0] blink_cnt;

  assign vis = layer_on & layer_mask & ~(blink_mask & {N_LAYERS{blink_phase}});

  always_ff @(posedge clk or posedge reset_game) begin
    if (reset_game) begin
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
    end else if (frame_tick) begin
      if (blink_cnt == 8'(BLINK_PERIOD-1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, 8'(BLINK_PERIOD)};
  assign vis = layer_on & layer_mask;
`endif

  // Scan from lowest priority upward so the lowest visible index wins.
  always_comb begin
    win_hit = 1'b0;
    win_sel = '0;
    win_rgb = bg_rgb;
    for (int k = N_LAYERS-1; k >= 0; k--) begin
      if (vis[k]) begin
        win_hit = 1'b1;
        win_sel = 4'(k);
        win_rgb = layer_rgb[12*k +: 12];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_game) begin
    if (reset_game) begin
      RGB_Out   <= '0;
      layer_hit <= 1'b0;
      layer_sel <= '0;
    end else if (!active) begin
      RGB_Out   <= '0;
      layer_hit <= 1'b0;
      layer_sel <= '0;
    end else begin
      RGB_Out   <= win_rgb;
      layer_hit <= win_hit;
      layer_sel <= win_sel;
    end
  end

  // A skipped event enters HOLD one count earlier so it spans the same
  // interval as PULSE+HOLD and cannot re-trigger on the same pixel.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    hold_nxt   = hold_cnt;
    frame_tick = 1'b0;
    case (state)
      IDLE: if (trig) begin
        if (div_cnt == 8'(FRAME_DIV-1)) begin
          div_nxt   = '0;
          state_nxt = PULSE;
        end else begin
          div_nxt   = div_cnt + 8'd1;
          hold_nxt  = '0;
          state_nxt = HOLD;
        end
      end
      PULSE: begin
        frame_tick = 1'b1;
        hold_nxt   = 4'd1;
        state_nxt  = HOLD;
      end
      HOLD: begin
        if (hold_cnt == 4'(HOLD_CYCLES)) state_nxt = IDLE;
        else hold_nxt = hold_cnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_game) begin
    if (reset_game) begin
      state       <= IDLE;
      div_cnt     <= '0;
      hold_cnt    <= '0;
      frame_count <= '0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      hold_cnt <= hold_nxt;
      if (frame_tick) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: priority/mask/background, tick divide,
// re-trigger guard, asynchronous reset mid-pulse and (when compiled in) blink.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        reset_game = 1'b1;
  logic        active = 1'b0;
  logic [9:0]  pixel_x = 10'd5;
  logic [9:0]  pixel_y = 10'd5;
  logic [3:0]  layer_on = '0;
  logic [47:0] layer_rgb = {12'hF00, 12'hFFF, 12'h0F0, 12'h00F};
  logic [3:0]  layer_mask = 4'hF;
  logic [3:0]  blink_mask = 4'b0001;
  logic [11:0] bg_rgb = 12'hF0F;

  logic [11:0] rgb1, rgb3;
  logic        hit1, hit3, tick1, tick3;
  logic [3:0]  sel1, sel3;
  logic [15:0] cnt1, cnt3;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  layer_compositor #(.N_LAYERS(4), .FRAME_DIV(1), .HOLD_CYCLES(2), .BLINK_PERIOD(2)) dut (
    .clk(clk), .reset_game(reset_game), .active(active), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .layer_mask(layer_mask), .blink_mask(blink_mask),
    .bg_rgb(bg_rgb), .RGB_Out(rgb1), .layer_hit(hit1), .layer_sel(sel1),
    .frame_tick(tick1), .frame_count(cnt1));

  layer_compositor #(.N_LAYERS(4), .FRAME_DIV(3), .HOLD_CYCLES(2), .BLINK_PERIOD(2)) dut3 (
    .clk(clk), .reset_game(reset_game), .active(active), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .layer_mask(layer_mask), .blink_mask(blink_mask),
    .bg_rgb(bg_rgb), .RGB_Out(rgb3), .layer_hit(hit3), .layer_sel(sel3),
    .frame_tick(tick3), .frame_count(cnt3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the trigger coordinate for 4 clk, then move away and watch 6 more clk.
  task automatic frame_event(output int t1, output int t3, output int first1, output int dbl);
    logic p1, p3;
    t1 = 0; t3 = 0; first1 = -1; dbl = 0; p1 = 1'b0; p3 = 1'b0;
    pixel_x = 10'd0;
    pixel_y = 10'd481;
    for (int c = 0; c < 10; c++) begin
      step();
      if (tick1) begin
        t1++;
        if (first1 < 0) first1 = c;
      end
      if (tick3) t3++;
      if ((tick1 && p1) || (tick3 && p3)) dbl++;
      p1 = tick1;
      p3 = tick3;
      if (c == 3) begin
        pixel_x = 10'd5;
        pixel_y = 10'd5;
      end
    end
  endtask

  initial begin
    int t1, t3, f1, dbl, tot1, tot3;
    logic [3:0] exp_sel;
    logic [11:0] exp_rgb;

    step();
    step();
    chk("rst_rgb", 32'(rgb1), 32'h0);
    chk("rst_hit", 32'(hit1), 32'h0);
    chk("rst_sel", 32'(sel1), 32'h0);
    chk("rst_tick", 32'(tick1), 32'h0);
    chk("rst_count", 32'(cnt1), 32'h0);
    reset_game = 1'b0;

    active = 1'b1; layer_on = 4'b1010; layer_mask = 4'hF;
    step();
    chk("prio_rgb", 32'(rgb1), 32'h0F0);
    chk("prio_sel", 32'(sel1), 32'd1);
    chk("prio_hit", 32'(hit1), 32'd1);

    layer_on = 4'b1000;
    step();
    chk("low_rgb", 32'(rgb1), 32'hF00);
    chk("low_sel", 32'(sel1), 32'd3);

    layer_on = 4'b0010; layer_mask = 4'b1101;
    step();
    chk("bg_rgb", 32'(rgb1), 32'hF0F);
    chk("bg_hit", 32'(hit1), 32'd0);
    chk("bg_sel", 32'(sel1), 32'd0);

    bg_rgb = 12'h123;
    step();
    chk("bg_change", 32'(rgb1), 32'h123);

    active = 1'b0;
    step();
    chk("inactive_rgb", 32'(rgb1), 32'h0);

    active = 1'b1; layer_on = 4'b1111; layer_mask = 4'hF;
    step();
    chk("top_rgb", 32'(rgb1), 32'h00F);
    chk("top_sel", 32'(sel1), 32'd0);

    // Six frame events: div-1 instance pulses every time, div-3 after events 3 and 6.
    tot1 = 0; tot3 = 0;
    for (int e = 1; e <= 6; e++) begin
      frame_event(t1, t3, f1, dbl);
      tot1 += t1;
      tot3 += t3;
      chk($sformatf("ev%0d_tick1", e), 32'(t1), 32'd1);
      chk($sformatf("ev%0d_tick3", e), 32'(t3), (e % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("ev%0d_width", e), 32'(dbl), 32'd0);
      if (e == 1) chk("ev1_latency", 32'(f1), 32'd0);
    end
    chk("div1_total", 32'(tot1), 32'd6);
    chk("div3_total", 32'(tot3), 32'd2);
    chk("div1_count", 32'(cnt1), 32'd6);
    chk("div3_count", 32'(cnt3), 32'd2);

    // Reset while the pulse is high.
    pixel_x = 10'd0; pixel_y = 10'd481;
    step();
    chk("pre_rst_tick", 32'(tick1), 32'd1);
    chk("pre_rst_rgb", 32'(rgb1), 32'h00F);
    reset_game = 1'b1;
    #1;
    chk("mid_rst_tick", 32'(tick1), 32'd0);
    chk("mid_rst_rgb", 32'(rgb1), 32'h0);
    chk("mid_rst_count", 32'(cnt1), 32'h0);
    chk("mid_rst_count3", 32'(cnt3), 32'h0);
    pixel_x = 10'd5; pixel_y = 10'd5;
    step();
    reset_game = 1'b0;
    step();
    frame_event(t1, t3, f1, dbl);
    chk("fresh_tick", 32'(t1), 32'd1);
    chk("fresh_latency", 32'(f1), 32'd0);
    chk("fresh_count", 32'(cnt1), 32'd1);

    // Blink: layer 0 blinks over layer 2, phase flips every 2 ticks.
    reset_game = 1'b1;
    step();
    reset_game = 1'b0;
    layer_on = 4'b0101; layer_mask = 4'hF; blink_mask = 4'b0001;
    step();
    chk("blink_start_sel", 32'(sel1), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      frame_event(t1, t3, f1, dbl);
`ifdef COMPOSITOR_BLINK_EN
      exp_sel = (e == 2 || e == 3) ? 4'd2 : 4'd0;
`else
      exp_sel = 4'd0;
`endif
      exp_rgb = (exp_sel == 4'd2) ? 12'hFFF : 12'h00F;
      chk($sformatf("blink%0d_sel", e), 32'(sel1), 32'(exp_sel));
      chk($sformatf("blink%0d_rgb", e), 32'(rgb1), 32'(exp_rgb));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
